// File: rtl/uart_line_pkg.sv
// Shared constants for the USB-UART line buffer: ASCII control bytes and FSM state encodings.
package uart_line_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_BS = 8'h08;

  typedef logic [1:0] state_t;

  localparam state_t ST_FILL    = 2'd0;
  localparam state_t ST_DRAIN   = 2'd1;
  localparam state_t ST_EMIT_LF = 2'd2;

endpackage

// File: rtl/line_ram.sv
// DEPTH x 8 simple dual-port RAM with registered read, shaped for iCE40 EBR inference.
module line_ram #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [7:0]               wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [7:0]               rd_data
);

  logic [7:0] mem [DEPTH];

  // NOTE: no reset on the array or read register; a reset port would stop EBR inference.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/uart_line_buffer.sv
// Collects host bytes into a line (with backspace editing), then echoes the whole line back,
// optionally followed by LF; force-flushes and flags overflow when the buffer fills.
module uart_line_buffer
  import uart_line_pkg::*;
#(
  parameter int          DEPTH  = 64,
  parameter logic [7:0]  TERM   = ASCII_CR,
  parameter bit          ADD_LF = 1'b1
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  state_t        state;
  logic [CW-1:0] count;
  logic [CW-1:0] rd_ptr;
  logic          term_seen;
  logic          primed;
  logic [7:0]    ram_data;

  logic accept;
  logic wr_en;
  logic launch;
  logic advance;
  logic last;
  logic rd_en;

  // NOTE: handshake decode is pure combinational logic; every signal gets a value on every path.
  always_comb begin
    in_ready = (state == ST_FILL);
    accept   = in_valid && in_ready;
    wr_en    = accept && (in_data != ASCII_BS);
    launch   = (state == ST_DRAIN) && !out_valid && primed;
    advance  = (state == ST_DRAIN) && out_valid && out_ready;
    last     = (rd_ptr == count);
    rd_en    = launch || (advance && !last);
    out_data = (state == ST_EMIT_LF) ? ASCII_LF : ram_data;
  end

  line_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk_48mhz),
    .wr_en   (wr_en),
    .wr_addr (count[AW-1:0]),
    .wr_data (in_data),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (ram_data)
  );

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state     <= ST_FILL;
      count     <= '0;
      rd_ptr    <= '0;
      term_seen <= 1'b0;
      primed    <= 1'b0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        ST_FILL: begin
          if (accept) begin
            if (in_data == ASCII_BS) begin
              if (count != '0) count <= count - CW'(1);
            end else begin
              count  <= count + CW'(1);
              rd_ptr <= '0;
              primed <= 1'b0;
              if (in_data == TERM) begin
                state     <= ST_DRAIN;
                term_seen <= 1'b1;
              end else if (count == CW'(DEPTH - 1)) begin
                state     <= ST_DRAIN;
                term_seen <= 1'b0;
                overflow  <= 1'b1;
              end
            end
          end
        end

        // One idle cycle, then the first read: out_valid rises two edges after the closing byte.
        ST_DRAIN: begin
          if (!primed) begin
            primed <= 1'b1;
          end else if (launch) begin
            rd_ptr    <= rd_ptr + CW'(1);
            out_valid <= 1'b1;
          end else if (advance) begin
            if (last) begin
              primed <= 1'b0;
              if (ADD_LF && term_seen) begin
                state <= ST_EMIT_LF;
              end else begin
                state     <= ST_FILL;
                count     <= '0;
                out_valid <= 1'b0;
              end
            end else begin
              rd_ptr <= rd_ptr + CW'(1);
            end
          end
        end

        ST_EMIT_LF: begin
          if (out_ready) begin
            state     <= ST_FILL;
            count     <= '0;
            term_seen <= 1'b0;
            out_valid <= 1'b0;
          end
        end

        default: begin
          state     <= ST_FILL;
          count     <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_line_buffer.sv
// Scoreboard bench for uart_line_buffer: a DEPTH=64 instance for line/edit/stall/reset cases
// and a DEPTH=4 instance for the overflow flush.
module tb_uart_line_buffer;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  logic       reset;
  logic [7:0] in_data, out_data, in_data4, out_data4;
  logic       in_valid, in_ready, out_valid, out_ready, overflow;
  logic       in_valid4, in_ready4, out_valid4, out_ready4, overflow4;

  int         checks = 0;
  int         failures = 0;
  int         hs_count = 0;
  bit         stall_mode = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp4_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  uart_line_buffer #(.DEPTH(64), .TERM(8'h0D), .ADD_LF(1'b1)) dut (
    .clk_48mhz (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow)
  );

  uart_line_buffer #(.DEPTH(4), .TERM(8'h0D), .ADD_LF(1'b1)) dut4 (
    .clk_48mhz (clk),
    .reset     (reset),
    .in_data   (in_data4),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .out_data  (out_data4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .overflow  (overflow4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for the main instance: pops the scoreboard on each handshake, checks hold while stalled.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out: got 0x%0h expected none", out_data);
        end else begin
          check("out_seq", 32'(out_data), 32'(exp_q.pop_front()));
        end
        hs_count++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  always @(negedge clk) begin
    if (!reset && out_valid4 && out_ready4) begin
      if (exp4_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out4: got 0x%0h expected none", out_data4);
      end else begin
        check("out4_seq", 32'(out_data4), 32'(exp4_q.pop_front()));
      end
    end
  end

  initial begin
    out_ready  = 1'b1;
    out_ready4 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send(input bit sel, input logic [7:0] b);
    @(negedge clk);
    if (sel) begin
      in_data4 = b; in_valid4 = 1'b1;
    end else begin
      in_data = b; in_valid = 1'b1;
    end
    for (int i = 0; i < 200; i++) begin
      if (sel ? in_ready4 : in_ready) begin
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_valid4 = 1'b0;
        return;
      end
      @(negedge clk);
    end
    checks++;
    failures++;
    $display("FAIL send_timeout: in_ready stayed low for byte 0x%0h", b);
    in_valid  = 1'b0;
    in_valid4 = 1'b0;
  endtask

  task automatic wait_idle(input bit sel, input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sel ? (exp4_q.size() == 0 && in_ready4 && !out_valid4)
              : (exp_q.size() == 0 && in_ready && !out_valid)) return;
    end
    checks++;
    failures++;
    $display("FAIL %s_timeout: line not fully drained within 300 cycles", name);
  endtask

  initial begin
    int base;
    bit seen;
    reset = 1'b1;
    in_data = 8'h00; in_valid = 1'b0;
    in_data4 = 8'h00; in_valid4 = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_in_ready4", 32'(in_ready4), 32'd1);
    check("rst_out_valid4", 32'(out_valid4), 32'd0);
    check("rst_overflow4", 32'(overflow4), 32'd0);

    // "AB" CR: out_valid two edges after CR, in_ready low until the LF handshake.
    exp_q = '{8'h41, 8'h42, 8'h0D, 8'h0A};
    send(0, 8'h41);
    send(0, 8'h42);
    send(0, 8'h0D);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("busy_in_ready", 32'(in_ready), 32'd0);
      if (i < 2) check("latency_low", 32'(out_valid), 32'd0);
      if (i == 2) check("latency_high", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    check("ready_after_lf", 32'(in_ready), 32'd1);
    wait_idle(0, "line_ab");

    // Backspace on an empty buffer, then editing inside a line.
    send(0, 8'h08);
    repeat (6) @(negedge clk);
    check("bs_empty_valid", 32'(out_valid), 32'd0);
    check("bs_empty_ready", 32'(in_ready), 32'd1);
    exp_q = '{8'h41, 8'h42, 8'h0D, 8'h0A};
    send(0, 8'h41);
    send(0, 8'h58);
    send(0, 8'h08);
    send(0, 8'h42);
    send(0, 8'h0D);
    wait_idle(0, "line_edit");

    // DEPTH=4 fills without a terminator: flush without LF, sticky overflow.
    exp4_q = '{8'h31, 8'h32, 8'h33, 8'h34};
    send(1, 8'h31);
    send(1, 8'h32);
    send(1, 8'h33);
    send(1, 8'h34);
    wait_idle(1, "overflow");
    repeat (8) @(negedge clk);
    check("ovf_flag4", 32'(overflow4), 32'd1);
    check("ovf_no_lf", 32'(out_valid4), 32'd0);
    check("ovf_flag64", 32'(overflow), 32'd0);

    // Random back-pressure while draining.
    stall_mode = 1'b1;
    exp_q = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0D, 8'h0A};
    send(0, 8'h48);
    send(0, 8'h45);
    send(0, 8'h4C);
    send(0, 8'h4C);
    send(0, 8'h4F);
    send(0, 8'h0D);
    wait_idle(0, "stall");
    stall_mode = 1'b0;
    repeat (2) @(posedge clk);

    // Reset after the second of five drained bytes.
    exp_q = '{8'h31, 8'h32};
    base = hs_count;
    send(0, 8'h31);
    send(0, 8'h32);
    send(0, 8'h33);
    send(0, 8'h34);
    send(0, 8'h0D);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (hs_count == base + 2) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL reset_wait_timeout: got %0d handshakes expected 2", hs_count - base);
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_ovf4_clear", 32'(overflow4), 32'd0);
    check("mid_rst_pending", 32'(exp_q.size()), 32'd0);

    exp_q = '{8'h5A, 8'h0D, 8'h0A};
    send(0, 8'h5A);
    send(0, 8'h0D);
    wait_idle(0, "after_reset");
    repeat (10) @(negedge clk);
    check("final_idle", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
